// File: rtl/wire_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// wire_cmd_sequencer_if
//  Register-bus bundle between the host command sequencer and the app core.
//  One request (reg_wr or reg_rd) is held until reg_ack or until the requester
//  gives up on a timeout. reg_rdata is sampled in the reg_ack cycle of a read.
//
//  Signals
//   reg_addr   master->slave  ADDR_W  bus address, valid while reg_wr|reg_rd
//   reg_wdata  master->slave  16      write data, valid while reg_wr
//   reg_wr     master->slave  1       write request
//   reg_rd     master->slave  1       read request
//   reg_ack    slave->master  1       acknowledge, one cycle
//   reg_rdata  slave->master  16      read data, valid with reg_ack on reads
//
//  Modports
//   master  the sequencer side (drives requests)
//   slave   the register-file side (drives ack/rdata)
// -----------------------------------------------------------------------------
interface wire_cmd_sequencer_if #(
   parameter int unsigned ADDR_W = 4
) ();

   logic [ADDR_W-1:0] reg_addr;
   logic [15:0]       reg_wdata;
   logic              reg_wr;
   logic              reg_rd;
   logic              reg_ack;
   logic [15:0]       reg_rdata;

   modport master (
      output reg_addr,
      output reg_wdata,
      output reg_wr,
      output reg_rd,
      input  reg_ack,
      input  reg_rdata
   );

   modport slave (
      input  reg_addr,
      input  reg_wdata,
      input  reg_wr,
      input  reg_rd,
      output reg_ack,
      output reg_rdata
   );

endinterface

// File: rtl/wire_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// wire_cmd_sequencer
//  Host-command sequencer behind the okWireIn endpoints. A command word and an
//  argument word are turned into single-outstanding register-bus transactions.
//  A new command is signalled by flipping cmd_word[15]; the sequencer compares
//  it against the toggle of the last accepted command, so no pulse endpoint is
//  needed. Each transaction is handshaked, bounded by a timeout, and reported
//  through a status word plus the last read data.
//
//  Parameters
//   TIMEOUT_CYCLES  cycles a request may stay unacknowledged (1..2^CNT_W-1)
//   CNT_W           timeout counter width
//   ADDR_W          register-bus address width (<= 8)
//
//  Ports
//   ti_clock   in   system clock, rising edge
//   ti_reset   in   asynchronous active-high reset
//   cmd_word   in   [15] toggle, [14:12] opcode, [ADDR_W-1:0] register address
//   arg_word   in   write data / readback compare value
//   rdata_out  out  data of the last successful read
//   status     out  [15] done_toggle [14] busy [13] err_timeout [12] err_illegal
//                   [11] overrun [10] verify_fail [9:0] zero
//   reg_bus    master side of the register bus
//
//  Opcodes: 0 NOP, 1 WRITE, 2 READ, 3 WRITE_VERIFY, 7 CLEAR, 4-6 illegal.
// -----------------------------------------------------------------------------
module wire_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8,
   parameter int unsigned ADDR_W         = 4
) (
   input  logic                 ti_clock,
   input  logic                 ti_reset,
   input  logic [15:0]          cmd_word,
   input  logic [15:0]          arg_word,
   output logic [15:0]          rdata_out,
   output logic [15:0]          status,
   wire_cmd_sequencer_if.master reg_bus
);

   localparam logic [2:0] OpNop      = 3'd0;
   localparam logic [2:0] OpWrite    = 3'd1;
   localparam logic [2:0] OpRead     = 3'd2;
   localparam logic [2:0] OpWrVerify = 3'd3;
   localparam logic [2:0] OpClear    = 3'd7;

   // Counter value of the last cycle a request may wait for its ack.
   localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StWr,
      StRd,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       arg_q, arg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_tog_q, last_tog_d;
   logic              prev_tog_q;
   logic              busy_q, busy_d;
   logic              done_tog_q, done_tog_d;
   logic              err_to_q, err_to_d;
   logic              err_ill_q, err_ill_d;
   logic              ovr_q, ovr_d;
   logic              vfail_q, vfail_d;
   logic [15:0]       rdata_q, rdata_d;

   logic              cmd_tog;
   logic [2:0]        cmd_op;
   logic              req_wr;
   logic              req_rd;
   logic              tmo_hit;

   assign cmd_tog = cmd_word[15];
   assign cmd_op  = cmd_word[14:12];

   // Command bits between the opcode and the address field carry no meaning.
   logic unused_cmd_bits;
   assign unused_cmd_bits = ^cmd_word[11:ADDR_W];

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge ti_clock or posedge ti_reset) begin
      if (ti_reset) begin
         state_q    <= StIdle;
         op_q       <= OpNop;
         addr_q     <= '0;
         arg_q      <= '0;
         cnt_q      <= '0;
         last_tog_q <= 1'b0;
         prev_tog_q <= 1'b0;
         busy_q     <= 1'b0;
         done_tog_q <= 1'b0;
         err_to_q   <= 1'b0;
         err_ill_q  <= 1'b0;
         ovr_q      <= 1'b0;
         vfail_q    <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         arg_q      <= arg_d;
         cnt_q      <= cnt_d;
         last_tog_q <= last_tog_d;
         prev_tog_q <= cmd_tog;
         busy_q     <= busy_d;
         done_tog_q <= done_tog_d;
         err_to_q   <= err_to_d;
         err_ill_q  <= err_ill_d;
         ovr_q      <= ovr_d;
         vfail_q    <= vfail_d;
         rdata_q    <= rdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   assign tmo_hit = (cnt_q == TmoLast);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      arg_d      = arg_q;
      cnt_d      = '0;
      last_tog_d = last_tog_q;
      busy_d     = busy_q;
      done_tog_d = done_tog_q;
      err_to_d   = err_to_q;
      err_ill_d  = err_ill_q;
      ovr_d      = ovr_q;
      vfail_d    = vfail_q;
      rdata_d    = rdata_q;

      // Any toggle movement while a command is in flight is lost, not queued.
      if ((state_q != StIdle) && (cmd_tog != prev_tog_q)) begin
         ovr_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (cmd_tog != last_tog_q) begin
               op_d       = cmd_op;
               addr_d     = cmd_word[ADDR_W-1:0];
               arg_d      = arg_word;
               last_tog_d = cmd_tog;
               busy_d     = 1'b1;
               case (cmd_op)
                  OpWrite, OpWrVerify: state_d = StWr;
                  OpRead:              state_d = StRd;
                  OpNop, OpClear:      state_d = StDone;
                  default: begin
                     err_ill_d = 1'b1;
                     state_d   = StDone;
                  end
               endcase
            end
         end

         StWr: begin
            // An ack in the last allowed cycle still counts as success.
            if (reg_bus.reg_ack) begin
               state_d = (op_q == OpWrVerify) ? StRd : StDone;
            end else if (tmo_hit) begin
               err_to_d = 1'b1;
               state_d  = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StRd: begin
            if (reg_bus.reg_ack) begin
               rdata_d = reg_bus.reg_rdata;
               if ((op_q == OpWrVerify) && (reg_bus.reg_rdata != arg_q)) begin
                  vfail_d = 1'b1;
               end
               state_d = StDone;
            end else if (tmo_hit) begin
               err_to_d = 1'b1;
               state_d  = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StDone: begin
            done_tog_d = last_tog_q;
            busy_d     = 1'b0;
            state_d    = StIdle;
            // Clearing overrides an overrun flagged in this same cycle.
            if (op_q == OpClear) begin
               err_to_d  = 1'b0;
               err_ill_d = 1'b0;
               ovr_d     = 1'b0;
               vfail_d   = 1'b0;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Requests decode straight from the state so that reset drops them at once.
   always_comb begin
      req_wr            = (state_q == StWr);
      req_rd            = (state_q == StRd);
      reg_bus.reg_wr    = req_wr;
      reg_bus.reg_rd    = req_rd;
      reg_bus.reg_addr  = (req_wr || req_rd) ? addr_q : '0;
      reg_bus.reg_wdata = req_wr ? arg_q : '0;
      rdata_out         = rdata_q;
      status            = {done_tog_q, busy_q, err_to_q, err_ill_q, ovr_q, vfail_q, 10'b0};
   end

endmodule

// File: tb/tb_wire_cmd_sequencer.sv
module tb_wire_cmd_sequencer;

   localparam int unsigned TMO    = 4;
   localparam int unsigned ADDR_W = 4;

   typedef struct {
      bit          is_wr;
      logic [3:0]  addr;
      logic [15:0] data;
   } txn_t;

   logic        ti_clock;
   logic        ti_reset = 1'b0;
   logic [15:0] cmd_word = 16'h0000;
   logic [15:0] arg_word = 16'h0000;
   logic [15:0] rdata_out;
   logic [15:0] status;

   int n_assert = 0;
   int n_fail   = 0;

   // Slave model controls and observations
   txn_t exp_q[$];
   bit          ack_en   = 1'b1;
   int          ack_wait = 0;
   logic [15:0] rd_val   = 16'h0000;
   int          txn_cnt  = 0;
   int          wr_high  = 0;

   wire_cmd_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   wire_cmd_sequencer #(
      .TIMEOUT_CYCLES(TMO),
      .CNT_W         (8),
      .ADDR_W        (ADDR_W)
   ) dut (
      .ti_clock (ti_clock),
      .ti_reset (ti_reset),
      .cmd_word (cmd_word),
      .arg_word (arg_word),
      .rdata_out(rdata_out),
      .status   (status),
      .reg_bus  (bus)
   );

   initial begin
      ti_clock = 1'b0;
      forever #5 ti_clock = ~ti_clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of test, required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge ti_clock);
         #1;
      end
   endtask

   task automatic issue(input logic [15:0] cmd, input logic [15:0] arg);
      cmd_word = cmd;
      arg_word = arg;
   endtask

   task automatic push(input bit is_wr, input logic [3:0] addr, input logic [15:0] data);
      txn_t t;
      t.is_wr = is_wr;
      t.addr  = addr;
      t.data  = data;
      exp_q.push_back(t);
   endtask

   // Waits (bounded) for done_toggle to reach tog; returns cycles spent.
   task automatic wait_done(input logic tog, output int lat);
      lat = 0;
      while ((status[15] !== tog) && (lat < 40)) begin
         step(1);
         lat++;
      end
      chk("done_toggle_reached", {31'd0, status[15]}, {31'd0, tog});
   endtask

   // Register-bus slave: acks after ack_wait cycles, checks each request
   // against the scoreboard when it first appears.
   initial begin : slave
      int   wait_cnt;
      bit   req_seen;
      txn_t e;
      wait_cnt      = 0;
      req_seen      = 1'b0;
      bus.reg_ack   = 1'b0;
      bus.reg_rdata = 16'h0000;
      forever begin
         @(negedge ti_clock);
         bus.reg_ack = 1'b0;
         chk("wr_rd_overlap", {31'd0, bus.reg_wr & bus.reg_rd}, 32'd0);
         if (bus.reg_wr || bus.reg_rd) begin
            if (bus.reg_wr) wr_high++;
            if (!req_seen) begin
               req_seen = 1'b1;
               wait_cnt = 0;
               txn_cnt++;
               chk("sb_expected_req", {31'd0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("req_kind_is_wr", {31'd0, bus.reg_wr}, {31'd0, e.is_wr});
                  chk("req_addr", {28'd0, bus.reg_addr}, {28'd0, e.addr});
                  if (e.is_wr) chk("req_wdata", {16'd0, bus.reg_wdata}, {16'd0, e.data});
               end
            end
            if (ack_en && (wait_cnt == ack_wait)) begin
               bus.reg_ack   = 1'b1;
               bus.reg_rdata = rd_val;
               req_seen      = 1'b0;
            end
            wait_cnt++;
         end else begin
            req_seen = 1'b0;
         end
      end
   end

   initial begin : main
      int lat;
      int base;

      // Reset
      #2 ti_reset = 1'b1;
      step(2);
      chk("rst_status", {16'd0, status}, 32'h0);
      chk("rst_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
      chk("rst_rdata_out", {16'd0, rdata_out}, 32'h0);
      ti_reset = 1'b0;
      step(3);
      chk("idle_status", {16'd0, status}, 32'h0);
      chk("idle_no_txn", txn_cnt, 32'd0);

      // WRITE addr 5 <- BEEF, zero-wait ack
      push(1'b1, 4'h5, 16'hBEEF);
      issue(16'h9005, 16'hBEEF);
      wait_done(1'b1, lat);
      chk("write_latency", lat, 32'd3);
      chk("write_status", {16'd0, status}, 32'h8000);

      // READ addr 3 -> 1234
      rd_val = 16'h1234;
      push(1'b0, 4'h3, 16'h0000);
      issue(16'h2003, 16'h0000);
      wait_done(1'b0, lat);
      chk("read_latency", lat, 32'd3);
      chk("read_rdata_out", {16'd0, rdata_out}, 32'h1234);
      chk("read_status", {16'd0, status}, 32'h0000);

      // WRITE_VERIFY with mismatching readback
      rd_val = 16'h00FE;
      push(1'b1, 4'hA, 16'h00FF);
      push(1'b0, 4'hA, 16'h0000);
      issue(16'hB00A, 16'h00FF);
      wait_done(1'b1, lat);
      chk("wv_latency", lat, 32'd4);
      chk("wv_fail_status", {16'd0, status}, 32'h8400);
      chk("wv_rdata_out", {16'd0, rdata_out}, 32'h00FE);

      // WRITE_VERIFY with matching readback: verify_fail stays sticky
      rd_val = 16'h00FF;
      push(1'b1, 4'hA, 16'h00FF);
      push(1'b0, 4'hA, 16'h0000);
      issue(16'h300A, 16'h00FF);
      wait_done(1'b0, lat);
      chk("wv_sticky_status", {16'd0, status}, 32'h0400);

      // CLEAR, no bus activity
      base = txn_cnt;
      issue(16'hF000, 16'h0000);
      wait_done(1'b1, lat);
      chk("clear_status", {16'd0, status}, 32'h8000);
      chk("clear_no_txn", txn_cnt - base, 32'd0);

      // WRITE timeout: request held exactly TMO cycles
      ack_en  = 1'b0;
      wr_high = 0;
      push(1'b1, 4'h7, 16'h5555);
      issue(16'h1007, 16'h5555);
      wait_done(1'b0, lat);
      chk("tmo_wr_cycles", wr_high, TMO);
      chk("tmo_status", {16'd0, status}, 32'h2000);

      // WRITE_VERIFY timeout on the write skips the read phase
      wr_high = 0;
      base    = txn_cnt;
      push(1'b1, 4'h1, 16'h0AAA);
      issue(16'hB001, 16'h0AAA);
      wait_done(1'b1, lat);
      step(3);
      chk("tmo_wv_one_txn", txn_cnt - base, 32'd1);
      chk("tmo_wv_status", {16'd0, status}, 32'hA000);

      // Ack in the timeout cycle wins
      ack_en = 1'b1;
      issue(16'h7000, 16'h0000);
      wait_done(1'b0, lat);
      chk("clear2_status", {16'd0, status}, 32'h0000);
      ack_wait = TMO - 1;
      wr_high  = 0;
      push(1'b1, 4'h2, 16'h1111);
      issue(16'h9002, 16'h1111);
      wait_done(1'b1, lat);
      chk("late_ack_wr_cycles", wr_high, TMO);
      chk("late_ack_status", {16'd0, status}, 32'h8000);

      // Two flips while busy: overrun, no extra transaction
      ack_wait = 2;
      base     = txn_cnt;
      push(1'b1, 4'h4, 16'h2222);
      issue(16'h1004, 16'h2222);
      step(1);
      issue(16'h9004, 16'h2222);
      step(1);
      issue(16'h1004, 16'h2222);
      wait_done(1'b0, lat);
      step(4);
      chk("ovr2_txn", txn_cnt - base, 32'd1);
      chk("ovr2_status", {16'd0, status}, 32'h0800);

      // One flip while busy: overrun plus one follow-on command
      issue(16'hF000, 16'h0000);
      wait_done(1'b1, lat);
      chk("clear3_status", {16'd0, status}, 32'h8000);
      base   = txn_cnt;
      rd_val = 16'hCAFE;
      push(1'b1, 4'h6, 16'h3333);
      push(1'b0, 4'h9, 16'h0000);
      issue(16'h1006, 16'h3333);
      step(1);
      issue(16'hA009, 16'h3333);
      wait_done(1'b0, lat);
      wait_done(1'b1, lat);
      step(3);
      chk("ovr1_txn", txn_cnt - base, 32'd2);
      chk("ovr1_status", {16'd0, status}, 32'h8800);
      chk("ovr1_rdata_out", {16'd0, rdata_out}, 32'hCAFE);

      // CLEAR removes overrun; illegal opcode sets err_illegal without bus activity
      ack_wait = 0;
      issue(16'h7000, 16'h0000);
      wait_done(1'b0, lat);
      chk("clear4_status", {16'd0, status}, 32'h0000);
      base = txn_cnt;
      issue(16'hD003, 16'h0000);
      wait_done(1'b1, lat);
      step(2);
      chk("illegal_status", {16'd0, status}, 32'h9000);
      chk("illegal_no_txn", txn_cnt - base, 32'd0);
      issue(16'h7000, 16'h0000);
      wait_done(1'b0, lat);
      chk("clear5_status", {16'd0, status}, 32'h0000);

      // Reset in the middle of a write
      ack_en = 1'b0;
      push(1'b1, 4'h8, 16'h4444);
      issue(16'h9008, 16'h4444);
      step(2);
      chk("pre_rst_reg_wr", {31'd0, bus.reg_wr}, 32'd1);
      ti_reset = 1'b1;
      #1;
      chk("midrst_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
      chk("midrst_reg_addr", {28'd0, bus.reg_addr}, 32'h0);
      chk("midrst_reg_wdata", {16'd0, bus.reg_wdata}, 32'h0);
      chk("midrst_status", {16'd0, status}, 32'h0);
      chk("midrst_rdata_out", {16'd0, rdata_out}, 32'h0);
      step(2);
      // Host toggle is still 1 after reset, so the command is taken again.
      ack_en   = 1'b1;
      ack_wait = 0;
      push(1'b1, 4'h8, 16'h4444);
      ti_reset = 1'b0;
      wait_done(1'b1, lat);
      chk("post_rst_latency", lat, 32'd3);
      chk("post_rst_status", {16'd0, status}, 32'h8000);

      step(2);
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
